// File: rtl/alarm_buzzer_driver.sv
// alarm_buzzer_driver: drives a piezo with bursts of square-wave beeps while
// an upstream alarm is active. Each burst is BEEP_CNT ON/OFF pairs, or runs
// without end when BEEP_CNT is 0. All outputs come straight from flops.
// Optional feature: define ALARM_BUZZER_MUTE_EN to add the mute_ack input.
// mute_ack silences the current burst until the alarm level drops.
module alarm_buzzer_driver #(
    parameter logic [31:0] TONE_DIV = 32'd25000,
    parameter logic [31:0] ON_CYC   = 32'd20000000,
    parameter logic [31:0] OFF_CYC  = 32'd30000000,
    parameter logic [7:0]  BEEP_CNT = 8'd3
) (
    input  logic ACLK,
    input  logic ARESETN,
    input  logic alarm_active,
    input  logic enable,
`ifdef ALARM_BUZZER_MUTE_EN
    input  logic mute_ack,
`endif
    output logic buzzer_out,
    output logic beep_active,
    output logic burst_done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_dur_cnt;
    logic [31:0] w_dur_cnt_next;
    logic [31:0] r_tone_cnt;
    logic [31:0] w_tone_cnt_next;
    logic [7:0]  r_beep_cnt;
    logic [7:0]  w_beep_cnt_next;
    logic        r_buzzer;
    logic        w_buzzer_next;
    logic        r_beep;
    logic        w_beep_next;
    logic        r_done;
    logic        w_done_next;

    logic        w_abort;
    logic        w_on_end;
    logic        w_off_end;
    logic        w_tone_end;
    logic        w_burst_end;
    logic [7:0]  w_beep_inc;

    // Losing either the alarm level or the enable ends the burst immediately.
    assign w_abort     = ~alarm_active | ~enable;
    // The duration counter holds the index of the current cycle in the phase.
    assign w_on_end    = (r_dur_cnt == (ON_CYC - 32'd1));
    assign w_off_end   = (r_dur_cnt == (OFF_CYC - 32'd1));
    assign w_tone_end  = (r_tone_cnt == (TONE_DIV - 32'd1));
    assign w_burst_end = (BEEP_CNT != 8'd0) && (r_beep_cnt == BEEP_CNT);
    // In continuous mode the beep count saturates rather than wrapping.
    assign w_beep_inc  = (r_beep_cnt == 8'hFF) ? r_beep_cnt : (r_beep_cnt + 8'd1);

    // Next-state and next-output logic; registered outputs default to holding.
    always_comb begin
        w_state_next    = r_state;
        w_dur_cnt_next  = r_dur_cnt;
        w_tone_cnt_next = r_tone_cnt;
        w_beep_cnt_next = r_beep_cnt;
        w_buzzer_next   = r_buzzer;
        w_beep_next     = r_beep;
        w_done_next     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_dur_cnt_next  = 32'd0;
                w_tone_cnt_next = 32'd0;
                w_beep_cnt_next = 8'd0;
                w_buzzer_next   = 1'b0;
                w_beep_next     = 1'b0;
                if (enable && alarm_active) begin
                    w_state_next    = ST_ON;
                    w_beep_cnt_next = 8'd1;
                    w_buzzer_next   = 1'b1;
                    w_beep_next     = 1'b1;
                end
            end

            ST_ON, ST_OFF: begin
                if (w_abort) begin
                    // Abort outranks both mute and a coinciding phase end.
                    w_state_next    = ST_IDLE;
                    w_dur_cnt_next  = 32'd0;
                    w_tone_cnt_next = 32'd0;
                    w_beep_cnt_next = 8'd0;
                    w_buzzer_next   = 1'b0;
                    w_beep_next     = 1'b0;
                end
`ifdef ALARM_BUZZER_MUTE_EN
                else if (mute_ack) begin
                    // Muted bursts park in DONE without the completion pulse.
                    w_state_next    = ST_DONE;
                    w_dur_cnt_next  = 32'd0;
                    w_tone_cnt_next = 32'd0;
                    w_beep_cnt_next = 8'd0;
                    w_buzzer_next   = 1'b0;
                    w_beep_next     = 1'b0;
                end
`endif
                else if (r_state == ST_ON) begin
                    if (w_on_end) begin
                        w_state_next    = ST_OFF;
                        w_dur_cnt_next  = 32'd0;
                        w_tone_cnt_next = 32'd0;
                        w_buzzer_next   = 1'b0;
                        w_beep_next     = 1'b0;
                    end else begin
                        w_dur_cnt_next = r_dur_cnt + 32'd1;
                        if (w_tone_end) begin
                            w_tone_cnt_next = 32'd0;
                            w_buzzer_next   = ~r_buzzer;
                        end else begin
                            w_tone_cnt_next = r_tone_cnt + 32'd1;
                        end
                    end
                end else begin
                    if (w_off_end) begin
                        w_dur_cnt_next  = 32'd0;
                        w_tone_cnt_next = 32'd0;
                        if (w_burst_end) begin
                            w_state_next    = ST_DONE;
                            w_beep_cnt_next = 8'd0;
                            w_done_next     = 1'b1;
                        end else begin
                            w_state_next    = ST_ON;
                            w_beep_cnt_next = w_beep_inc;
                            w_buzzer_next   = 1'b1;
                            w_beep_next     = 1'b1;
                        end
                    end else begin
                        w_dur_cnt_next = r_dur_cnt + 32'd1;
                    end
                end
            end

            ST_DONE: begin
                // Stay silent until the alarm level drops, so a held alarm
                // does not retrigger a second burst.
                w_buzzer_next = 1'b0;
                w_beep_next   = 1'b0;
                if (!alarm_active || !enable) begin
                    w_state_next = ST_IDLE;
                end
            end

            default: begin
                w_state_next    = ST_IDLE;
                w_dur_cnt_next  = 32'd0;
                w_tone_cnt_next = 32'd0;
                w_beep_cnt_next = 8'd0;
                w_buzzer_next   = 1'b0;
                w_beep_next     = 1'b0;
            end
        endcase
    end

    // State, counter and output registers with synchronous active-low reset.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_state    <= ST_IDLE;
            r_dur_cnt  <= 32'd0;
            r_tone_cnt <= 32'd0;
            r_beep_cnt <= 8'd0;
            r_buzzer   <= 1'b0;
            r_beep     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_dur_cnt  <= w_dur_cnt_next;
            r_tone_cnt <= w_tone_cnt_next;
            r_beep_cnt <= w_beep_cnt_next;
            r_buzzer   <= w_buzzer_next;
            r_beep     <= w_beep_next;
            r_done     <= w_done_next;
        end
    end

    assign buzzer_out  = r_buzzer;
    assign beep_active = r_beep;
    assign burst_done  = r_done;

endmodule

// File: tb/tb_alarm_buzzer_driver.sv
// Bench for alarm_buzzer_driver: a table of per-cycle vectors for a burst
// instance (BEEP_CNT=2), hand sequences for reset and mute, and a second
// instance in continuous mode (BEEP_CNT=0).
module tb_alarm_buzzer_driver;

    logic ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    logic rst_a, alarm_a, en_a;
    logic buz_a, beep_a, done_a;
    logic rst_b, alarm_b, en_b;
    logic buz_b, beep_b, done_b;
`ifdef ALARM_BUZZER_MUTE_EN
    logic mute_a, mute_b;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       alarm;
        logic       en;
        logic [2:0] exp;   // {buzzer_out, beep_active, burst_done}
    } vec_t;

    vec_t        vecs[$];
    logic [11:0] pat;      // buzzer level for each cycle of one ON/OFF pair

    alarm_buzzer_driver #(
        .TONE_DIV(32'd2), .ON_CYC(32'd8), .OFF_CYC(32'd4), .BEEP_CNT(8'd2)
    ) dut_a (
        .ACLK(ACLK),
        .ARESETN(rst_a),
        .alarm_active(alarm_a),
        .enable(en_a),
`ifdef ALARM_BUZZER_MUTE_EN
        .mute_ack(mute_a),
`endif
        .buzzer_out(buz_a),
        .beep_active(beep_a),
        .burst_done(done_a)
    );

    alarm_buzzer_driver #(
        .TONE_DIV(32'd2), .ON_CYC(32'd8), .OFF_CYC(32'd4), .BEEP_CNT(8'd0)
    ) dut_b (
        .ACLK(ACLK),
        .ARESETN(rst_b),
        .alarm_active(alarm_b),
        .enable(en_b),
`ifdef ALARM_BUZZER_MUTE_EN
        .mute_ack(mute_b),
`endif
        .buzzer_out(buz_b),
        .beep_active(beep_b),
        .burst_done(done_b)
    );

    function automatic void add(input logic a, input logic e, input logic [2:0] x);
        vecs.push_back('{alarm: a, en: e, exp: x});
    endfunction

    // First n cycles of an ON phase with alarm and enable held.
    function automatic void add_on(input int n);
        for (int i = 0; i < n; i++) add(1'b1, 1'b1, {pat[11-i], 1'b1, 1'b0});
    endfunction

    // A full two-beep burst followed by the burst_done cycle.
    function automatic void add_burst();
        for (int i = 0; i < 24; i++) begin
            int k;
            k = i % 12;
            add(1'b1, 1'b1, {pat[11-k], (k < 8), 1'b0});
        end
        add(1'b1, 1'b1, 3'b001);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic step_a(input logic rst, input logic a, input logic e,
                          input logic [2:0] exp, input string name);
        rst_a   = rst;
        alarm_a = a;
        en_a    = e;
        @(posedge ACLK);
        #1;
        check(name, {29'd0, buz_a, beep_a, done_a}, {29'd0, exp});
    endtask

    initial begin
        int rises;
        logic prev;

        pat = 12'b1100_1100_0000;

        // Two full bursts, DONE held 50 cycles, retrigger after a 1-cycle drop.
        add_burst();
        for (int i = 0; i < 50; i++) add(1'b1, 1'b1, 3'b000);
        add(1'b0, 1'b1, 3'b000);
        add_burst();
        // enable low in DONE goes straight to IDLE; next edge restarts.
        add(1'b1, 1'b0, 3'b000);
        // Abort by alarm drop during the 5th ON cycle.
        add_on(5);
        for (int i = 0; i < 6; i++) add(1'b0, 1'b1, 3'b000);
        // Abort by enable drop during OFF.
        add_on(8);
        add(1'b1, 1'b1, 3'b000);
        for (int i = 0; i < 5; i++) add(1'b1, 1'b0, 3'b000);
        // Abort coinciding with the end of OFF: abort must win.
        add_on(8);
        for (int i = 0; i < 4; i++) add(1'b1, 1'b1, 3'b000);
        add(1'b0, 1'b1, 3'b000);
        add(1'b0, 1'b1, 3'b000);

        rst_b   = 1'b0;
        alarm_b = 1'b0;
        en_b    = 1'b0;
`ifdef ALARM_BUZZER_MUTE_EN
        mute_a  = 1'b0;
        mute_b  = 1'b0;
`endif

        // Reset with alarm asserted keeps everything quiet.
        for (int i = 0; i < 5; i++) step_a(1'b0, 1'b1, 1'b1, 3'b000, "reset");

        foreach (vecs[i])
            step_a(1'b1, vecs[i].alarm, vecs[i].en, vecs[i].exp, $sformatf("vec%0d", i));

        // Reset mid-burst, then a fresh burst from a held alarm.
        step_a(1'b1, 1'b1, 1'b1, 3'b110, "rst_mid_on0");
        step_a(1'b1, 1'b1, 1'b1, 3'b110, "rst_mid_on1");
        step_a(1'b1, 1'b1, 1'b1, 3'b010, "rst_mid_on2");
        step_a(1'b0, 1'b1, 1'b1, 3'b000, "rst_mid_hit");
        step_a(1'b1, 1'b1, 1'b1, 3'b110, "rst_fresh0");
        step_a(1'b1, 1'b1, 1'b1, 3'b110, "rst_fresh1");
        step_a(1'b1, 1'b1, 1'b1, 3'b010, "rst_fresh2");
        step_a(1'b1, 1'b0, 1'b1, 3'b000, "rst_fresh_abort");

`ifdef ALARM_BUZZER_MUTE_EN
        // Mute during the second ON phase.
        for (int i = 0; i < 14; i++) begin
            int k;
            k = i % 12;
            step_a(1'b1, 1'b1, 1'b1, {pat[11-k], (k < 8), 1'b0}, $sformatf("mute_pre%0d", i));
        end
        mute_a = 1'b1;
        step_a(1'b1, 1'b1, 1'b1, 3'b000, "mute_hit");
        mute_a = 1'b0;
        for (int i = 0; i < 20; i++) step_a(1'b1, 1'b1, 1'b1, 3'b000, "mute_hold");
        step_a(1'b1, 1'b0, 1'b1, 3'b000, "mute_release");
        step_a(1'b1, 1'b1, 1'b1, 3'b110, "mute_restart");
        step_a(1'b1, 1'b0, 1'b1, 3'b000, "mute_end");
`endif

        // Continuous mode: 200 cycles with the alarm held.
        rst_b   = 1'b1;
        alarm_b = 1'b1;
        en_b    = 1'b1;
        rises   = 0;
        prev    = 1'b0;
        for (int j = 0; j < 200; j++) begin
            int k;
            k = j % 12;
            @(posedge ACLK);
            #1;
            check($sformatf("cont%0d", j), {29'd0, buz_b, beep_b, done_b},
                  {29'd0, pat[11-k], (k < 8), 1'b0});
            if (beep_b && !prev) rises++;
            prev = beep_b;
        end
        check("cont_beeps", rises, 32'd17);
        alarm_b = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
